// File: rtl/bcd_scan_display_n.sv
// Binary-to-BCD converter and multiplexed common-anode 7-segment driver.
// A loaded binary value is converted by a shift-add-3 engine, one bit per
// clock. The finished result is latched for display. A prescaled scan
// counter cycles through the digits.
module bcd_scan_display_n #(
  parameter int DATA_W  = 8,
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 50000
) (
  input  logic                  clkNexys2,
  input  logic                  Reset,
  input  logic                  load,
  input  logic [DATA_W-1:0]     value,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     anodoComun,
  output logic [7:0]            ledsDisplay
);

  localparam int ACC_W = 4 * (DIGITS + 1);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int PRE_W = $clog2(CLK_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   shreg, sh_nxt;
  logic [ACC_W-1:0]    acc, acc_adj, acc_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                last;
  logic [PRE_W-1:0]    presc;
  logic [IDX_W-1:0]    idx;
  logic [DIGITS-1:0]   blank;
  logic [3:0]          cur;

  assign last = (cnt == CNT_W'(DATA_W - 1));

  // FSM state register
  always_ff @(posedge clkNexys2) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state == SHIFT);
  end

  // Add-3 correction on every accumulator nibble, then one-bit left shift
  always_comb begin
    acc_adj = '0;
    for (int unsigned i = 0; i < DIGITS + 1; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      else                       acc_adj[4*i +: 4] = acc[4*i +: 4];
    end
    {acc_nxt, sh_nxt} = {acc_adj[ACC_W-2:0], shreg, 1'b0};
  end

  // Conversion datapath; result and overflow update only on the final shift
  always_ff @(posedge clkNexys2) begin
    if (Reset) begin
      shreg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      bcd_out <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shreg <= value;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          shreg <= sh_nxt;
          acc   <= acc_nxt;
          cnt   <= cnt + 1'b1;
          if (last) begin
            bcd_out <= acc_nxt[4*DIGITS-1:0];
            ovf     <= |acc_nxt[ACC_W-1 -: 4];
          end
        end
        default: ;
      endcase
    end
  end

  // Refresh prescaler and digit scan index
  always_ff @(posedge clkNexys2) begin
    if (Reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRE_W'(CLK_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Leading-zero map: digits above the most significant nonzero digit
  always_comb begin
    logic seen;
    seen  = 1'b0;
    blank = '0;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      if (bcd_out[4*(DIGITS-1-j) +: 4] != 4'd0) seen = 1'b1;
      blank[DIGITS-1-j] = !seen && (j != DIGITS - 1);
    end
  end

  // Anode select and segment pattern for the scanned digit
  always_comb begin
    anodoComun      = '1;
    anodoComun[idx] = 1'b0;
    cur             = bcd_out[4*int'(idx) +: 4];
    if (ovf) begin
      ledsDisplay = 8'hFD;
    end else if (blank_lz && blank[idx]) begin
      ledsDisplay = 8'hFF;
    end else begin
      case (cur)
        4'd0:    ledsDisplay = 8'h03;
        4'd1:    ledsDisplay = 8'h9F;
        4'd2:    ledsDisplay = 8'h25;
        4'd3:    ledsDisplay = 8'h0D;
        4'd4:    ledsDisplay = 8'h99;
        4'd5:    ledsDisplay = 8'h49;
        4'd6:    ledsDisplay = 8'h41;
        4'd7:    ledsDisplay = 8'h1F;
        4'd8:    ledsDisplay = 8'h01;
        4'd9:    ledsDisplay = 8'h09;
        default: ledsDisplay = 8'hFF;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_scan_display_n.sv
// Scoreboard bench: stimulus pushes expected conversion results, per-DUT
// monitors pop and compare on every busy falling edge.
module tb_bcd_scan_display_n;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst8, load8, blank8;
  logic [7:0]  value8;
  logic        busy8, ovf8;
  logic [15:0] bcd8;
  logic [3:0]  an8;
  logic [7:0]  seg8;

  logic        rst16, load16, blank16;
  logic [15:0] value16;
  logic        busy16, ovf16;
  logic [15:0] bcd16;
  logic [3:0]  an16;
  logic [7:0]  seg16;

  int ncmp  = 0;
  int nfail = 0;

  exp_t q8[$];
  exp_t q16[$];
  bit   abort8 = 1'b0;

  always #5 clk = ~clk;

  bcd_scan_display_n #(.DATA_W(8), .DIGITS(4), .CLK_DIV(4)) dut8 (
    .clkNexys2(clk), .Reset(rst8), .load(load8), .value(value8),
    .blank_lz(blank8), .busy(busy8), .ovf(ovf8), .bcd_out(bcd8),
    .anodoComun(an8), .ledsDisplay(seg8));

  bcd_scan_display_n #(.DATA_W(16), .DIGITS(4), .CLK_DIV(4)) dut16 (
    .clkNexys2(clk), .Reset(rst16), .load(load16), .value(value16),
    .blank_lz(blank16), .busy(busy16), .ovf(ovf16), .bcd_out(bcd16),
    .anodoComun(an16), .ledsDisplay(seg16));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the 8-bit instance
  int   bc8 = 0;
  logic pb8 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (busy8 === 1'b1) bc8++;
    if (pb8 === 1'b1 && busy8 === 1'b0) begin
      if (abort8) begin
        abort8 = 1'b0;
      end else if (q8.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL done8_unexpected: got completion, expected none");
      end else begin
        e = q8.pop_front();
        check("bcd8", bcd8, e.bcd);
        check("ovf8", ovf8, e.ovf);
        check("lat8", bc8, 8);
      end
      bc8 = 0;
    end
    pb8 = busy8;
  end

  // Monitor for the 16-bit instance
  int   bc16 = 0;
  logic pb16 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (busy16 === 1'b1) bc16++;
    if (pb16 === 1'b1 && busy16 === 1'b0) begin
      if (q16.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL done16_unexpected: got completion, expected none");
      end else begin
        e = q16.pop_front();
        check("bcd16", bcd16, e.bcd);
        check("ovf16", ovf16, e.ovf);
        check("lat16", bc16, 16);
      end
      bc16 = 0;
    end
    pb16 = busy16;
  end

  task automatic wait_idle(input int sel);
    int n = 0;
    while (((sel == 0) ? busy8 : busy16) !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      ncmp++;
      nfail++;
      $display("FAIL idle_timeout: got busy after %0d cycles, expected idle", n);
    end
    tick();
  endtask

  task automatic seg(input int sel, input int d, input logic [7:0] exp, input string name);
    int n = 0;
    logic [3:0] want;
    want = ~(4'b0001 << d);
    while (((sel == 0) ? an8 : an16) !== want && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) begin
      ncmp++;
      nfail++;
      $display("FAIL %s_timeout: got anode never %b, expected it within 64 cycles", name, want);
    end else begin
      check(name, (sel == 0) ? seg8 : seg16, exp);
    end
  endtask

  logic [3:0] ring [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  logic [7:0] seg255 [4] = '{8'h49, 8'h49, 8'h25, 8'hFF};

  initial begin
    rst8 = 1'b1; load8 = 1'b0; blank8 = 1'b1; value8 = '0;
    rst16 = 1'b1; load16 = 1'b0; blank16 = 1'b0; value16 = '0;

    // 1. reset state and anode ring
    tick(); tick();
    check("rst_busy", busy8, 1'b0);
    check("rst_ovf", ovf8, 1'b0);
    check("rst_bcd", bcd8, 16'h0000);
    check("rst_an", an8, 4'b1110);
    check("rst_seg", seg8, 8'h03);
    rst8 = 1'b0; rst16 = 1'b0;
    for (int s = 0; s < 4; s++) begin
      repeat (4) tick();
      check("ring", an8, ring[s]);
    end

    // 2. 255 with leading-zero blanking
    value8 = 8'd255; load8 = 1'b1;
    tick();
    load8 = 1'b0;
    q8.push_back('{16'h0255, 1'b0});
    check("busy_rise", busy8, 1'b1);
    repeat (7) tick();
    check("busy_k7", busy8, 1'b1);
    tick();
    check("busy_k8", busy8, 1'b0);
    check("bcd_k8", bcd8, 16'h0255);
    for (int d = 0; d < 4; d++) seg(0, d, seg255[d], "seg255");

    // 3. load while busy ignored, then restart right after completion
    value8 = 8'd37; load8 = 1'b1;
    tick();
    load8 = 1'b0;
    q8.push_back('{16'h0037, 1'b0});
    tick(); tick();
    value8 = 8'd99; load8 = 1'b1;
    tick();
    load8 = 1'b0;
    repeat (5) tick();
    check("bcd37", bcd8, 16'h0037);
    check("idle37", busy8, 1'b0);
    value8 = 8'd99; load8 = 1'b1;
    tick();
    load8 = 1'b0;
    q8.push_back('{16'h0099, 1'b0});
    check("restart", busy8, 1'b1);
    wait_idle(0);

    // 6. reset mid-conversion together with a load
    value8 = 8'd200; load8 = 1'b1;
    tick();
    load8 = 1'b0;
    abort8 = 1'b1;
    tick(); tick();
    rst8 = 1'b1; load8 = 1'b1; value8 = 8'd55;
    tick();
    check("abort_busy", busy8, 1'b0);
    check("abort_bcd", bcd8, 16'h0000);
    check("abort_an", an8, 4'b1110);
    rst8 = 1'b0; load8 = 1'b0;
    tick();
    check("abort_noload", busy8, 1'b0);

    // 4. zero with and without blanking
    value8 = 8'd0; load8 = 1'b1;
    tick();
    load8 = 1'b0;
    q8.push_back('{16'h0000, 1'b0});
    wait_idle(0);
    blank8 = 1'b1;
    seg(0, 0, 8'h03, "zero_d0");
    for (int d = 1; d < 4; d++) seg(0, d, 8'hFF, "zero_blank");
    blank8 = 1'b0;
    for (int d = 0; d < 4; d++) seg(0, d, 8'h03, "zero_noblank");

    // 5. 16-bit instance: overflow and max displayable
    value16 = 16'd12345; load16 = 1'b1;
    tick();
    load16 = 1'b0;
    q16.push_back('{16'h2345, 1'b1});
    wait_idle(1);
    for (int d = 0; d < 4; d++) seg(1, d, 8'hFD, "ovf_dash");
    value16 = 16'd9999; load16 = 1'b1;
    tick();
    load16 = 1'b0;
    q16.push_back('{16'h9999, 1'b0});
    wait_idle(1);
    blank16 = 1'b1;
    seg(1, 3, 8'h09, "seg9999_d3");

    repeat (4) tick();
    check("q8_empty", q8.size(), 0);
    check("q16_empty", q16.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
